// File: rtl/frame_fifo_ctrl.sv
// Store-and-forward frame FIFO controller driving an external DUALRAM.
// Good frames are committed on EOF; bad or oversized frames are rewound.
module frame_fifo_ctrl #(
    parameter int AWIDTH = 6,
    parameter int DWIDTH = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              WR_VALID,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              WR_EOF,
    input  logic              WR_BAD,
    output logic              WR_READY,
    output logic              RD_VALID,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              RD_EOF,
    input  logic              RD_READY,
    output logic              RAM_WE,
    output logic [AWIDTH-1:0] RAM_WADDR,
    output logic [DWIDTH:0]   RAM_WDATA,
    output logic [AWIDTH-1:0] RAM_RADDR,
    input  logic [DWIDTH:0]   RAM_RDATA,
    output logic [AWIDTH:0]   FRAMES,
    output logic [AWIDTH:0]   LEVEL,
    output logic              OVERFLOW
);

    typedef enum logic {S_WRITE, S_DROP} wstate_t;

    wstate_t         state, state_n;
    logic [AWIDTH:0] wcur, wcom, rptr, rfree;
    logic [AWIDTH:0] wcur_n, wcom_n;
    logic [AWIDTH:0] level, avail, depth_w;
    logic            full, ovf, we, commit, wr_rdy;

    logic [DWIDTH:0] buf0, buf1, buf0_n, buf1_n;
    logic [1:0]      occ;
    logic            inflight, pop, issue;
    logic [2:0]      occ_next;
    logic [AWIDTH:0] frames;

    assign depth_w = {1'b1, {AWIDTH{1'b0}}};
    assign level   = wcur - rfree;
    assign full    = (level == depth_w);
    assign avail   = wcom - rptr;

    always_comb begin
        state_n = state;
        wcur_n  = wcur;
        wcom_n  = wcom;
        wr_rdy  = 1'b1;
        we      = 1'b0;
        ovf     = 1'b0;
        commit  = 1'b0;
        case (state)
            S_WRITE: begin
                // A full RAM holding only the frame in progress cannot drain,
                // so that frame is dropped instead of stalling the writer.
                wr_rdy = !full || (wcom == rfree);
                if (WR_VALID && full && (wcom == rfree)) begin
                    ovf    = 1'b1;
                    wcur_n = wcom;
                    if (!WR_EOF) state_n = S_DROP;
                end else if (WR_VALID && wr_rdy) begin
                    we = 1'b1;
                    if (WR_EOF && WR_BAD) begin
                        wcur_n = wcom;
                    end else begin
                        wcur_n = wcur + 1'b1;
                    end
                    if (WR_EOF && !WR_BAD) begin
                        wcom_n = wcur + 1'b1;
                        commit = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (WR_VALID && WR_EOF) state_n = S_WRITE;
            end
            default: state_n = S_WRITE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_WRITE;
            wcur  <= '0;
            wcom  <= '0;
        end else begin
            state <= state_n;
            wcur  <= wcur_n;
            wcom  <= wcom_n;
        end
    end

    assign pop      = (occ != 2'd0) && RD_READY;
    assign occ_next = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue    = (avail != '0) && (occ_next < 3'd2);

    // Incoming RAM word lands in whichever slot is next free after this cycle's pop.
    always_comb begin
        buf0_n = buf0;
        buf1_n = buf1;
        if (pop) buf0_n = buf1;
        if (inflight) begin
            if (occ_next == 3'd1) buf0_n = RAM_RDATA;
            else                  buf1_n = RAM_RDATA;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rptr     <= '0;
            rfree    <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            frames   <= '0;
        end else begin
            if (issue) rptr <= rptr + 1'b1;
            if (pop)   rfree <= rfree + 1'b1;
            inflight <= issue;
            occ      <= occ_next[1:0];
            buf0     <= buf0_n;
            buf1     <= buf1_n;
            if (commit && !(pop && buf0[DWIDTH])) begin
                frames <= frames + 1'b1;
            end else if (!commit && pop && buf0[DWIDTH]) begin
                frames <= frames - 1'b1;
            end
        end
    end

    assign WR_READY  = wr_rdy;
    assign RAM_WE    = we & RSTN;
    assign OVERFLOW  = ovf & RSTN;
    assign RAM_WADDR = wcur[AWIDTH-1:0];
    assign RAM_WDATA = {WR_EOF, WR_DATA};
    assign RAM_RADDR = rptr[AWIDTH-1:0];
    assign RD_VALID  = (occ != 2'd0);
    assign RD_DATA   = buf0[DWIDTH-1:0];
    assign RD_EOF    = buf0[DWIDTH];
    assign FRAMES    = frames;
    assign LEVEL     = level;

endmodule

// File: tb/tb_frame_fifo_ctrl.sv
// Bench for frame_fifo_ctrl: directed scenarios plus random traffic checked
// against a frame-queue reference model, with a behavioural RAM attached.
`timescale 1ns/1ps
module tb_frame_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2**AW;

    logic          CLK, RSTN;
    logic          WR_VALID, WR_EOF, WR_BAD, WR_READY;
    logic [DW-1:0] WR_DATA, RD_DATA;
    logic          RD_VALID, RD_EOF, RD_READY;
    logic          RAM_WE, OVERFLOW;
    logic [AW-1:0] RAM_WADDR, RAM_RADDR;
    logic [DW:0]   RAM_WDATA, RAM_RDATA;
    logic [AW:0]   FRAMES, LEVEL;

    frame_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_EOF(WR_EOF), .WR_BAD(WR_BAD),
        .WR_READY(WR_READY),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_EOF(RD_EOF), .RD_READY(RD_READY),
        .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_RADDR(RAM_RADDR), .RAM_RDATA(RAM_RDATA),
        .FRAMES(FRAMES), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
    );

    logic [DW:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_WADDR] <= RAM_WDATA;
        RAM_RDATA <= mem[RAM_RADDR];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen = 0;
    bit rand_rd  = 0;

    // Reference model: committed words awaiting read, the open frame, drop mode.
    logic [DW:0] q_out[$];
    logic [DW:0] cur[$];
    bit          dropping = 0;
    int          mframes  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_out.delete();
        cur.delete();
        dropping = 0;
        mframes  = 0;
    endtask

    task automatic cycle(output bit acc);
        bit exp_ready, exp_ovf;
        @(negedge CLK);
        exp_ready = dropping || (q_out.size() + cur.size() != DEPTH) || (q_out.size() == 0);
        exp_ovf   = !dropping && WR_VALID && (cur.size() == DEPTH);
        acc       = WR_VALID && exp_ready;
        check("wr_ready", WR_READY, exp_ready);
        check("level", LEVEL, q_out.size() + cur.size());
        check("frames", FRAMES, mframes);
        check("overflow", OVERFLOW, exp_ovf);
        check("ram_we", RAM_WE, acc && !dropping && !exp_ovf);
        if (OVERFLOW === 1'b1) ovf_seen++;
        if (q_out.size() == 0) check("rdv_empty", RD_VALID, 1'b0);
        if (RD_VALID && RD_READY && q_out.size() != 0) begin
            check("rd_word", {RD_EOF, RD_DATA}, q_out[0]);
            if (q_out[0][DW]) mframes--;
            void'(q_out.pop_front());
        end
        if (acc) begin
            if (dropping) begin
                if (WR_EOF) dropping = 0;
            end else if (exp_ovf) begin
                cur.delete();
                dropping = !WR_EOF;
            end else if (WR_EOF) begin
                if (!WR_BAD) begin
                    foreach (cur[i]) q_out.push_back(cur[i]);
                    q_out.push_back({1'b1, WR_DATA});
                    mframes++;
                end
                cur.delete();
            end else begin
                cur.push_back({1'b0, WR_DATA});
            end
        end
        @(posedge CLK);
        #1;
        if (rand_rd) RD_READY = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit eof, input bit bad);
        bit a;
        int n;
        n = 0;
        WR_VALID = 1'b1; WR_DATA = d; WR_EOF = eof; WR_BAD = bad;
        do begin
            cycle(a);
            n++;
        end while (!a && n < 200);
        check("send_accept", a, 1'b1);
        WR_VALID = 1'b0; WR_EOF = 1'b0; WR_BAD = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        WR_VALID = 1'b0;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit a;
        RSTN = 1'b0; WR_VALID = 1'b0; WR_DATA = '0; WR_EOF = 1'b0; WR_BAD = 1'b0;
        RD_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rdv", RD_VALID, 1'b0);
        check("rst_we", RAM_WE, 1'b0);
        check("rst_waddr", RAM_WADDR, 0);
        check("rst_raddr", RAM_RADDR, 0);
        RSTN = 1'b1;
        #1;
        check("rel_wr_ready", WR_READY, 1'b1);
        check("rel_rdv", RD_VALID, 1'b0);
        check("rel_frames", FRAMES, 0);
        check("rel_level", LEVEL, 0);
        check("rel_ovf", OVERFLOW, 1'b0);

        // Good frame and read latency
        RD_READY = 1'b1;
        send(32'hA1, 0, 0);
        send(32'hA2, 0, 0);
        send(32'hA3, 1, 0);
        check("lat_frames", FRAMES, 1);
        check("lat_n1", RD_VALID, 1'b0);
        idle(1);
        check("lat_n2", RD_VALID, 1'b0);
        idle(1);
        check("lat_n3", {RD_VALID, RD_EOF, RD_DATA}, {2'b10, 32'hA1});
        idle(1);
        check("lat_n4", {RD_VALID, RD_EOF, RD_DATA}, {2'b10, 32'hA2});
        idle(1);
        check("lat_n5", {RD_VALID, RD_EOF, RD_DATA}, {2'b11, 32'hA3});
        idle(1);
        check("lat_done_frames", FRAMES, 0);
        check("lat_done_level", LEVEL, 0);

        // Bad frame rewound, then single-word good frame
        for (int i = 0; i < 4; i++) send(32'hBAD0 + i, i == 3, i == 3);
        check("bad_level", LEVEL, 0);
        send(32'hB1, 1, 0);
        idle(6);
        check("bad_drained", q_out.size(), 0);

        // Oversized frame into empty FIFO
        base = ovf_seen;
        for (int i = 1; i <= 16; i++) send(32'h100 + i, 0, 0);
        check("ovf_level16", LEVEL, 16);
        send(32'h111, 0, 0);
        check("ovf_level0", LEVEL, 0);
        for (int i = 18; i <= 20; i++) send(32'h100 + i, i == 20, 0);
        check("ovf_count", ovf_seen - base, 1);
        send(32'hC1, 0, 0);
        send(32'hC2, 1, 0);
        idle(8);
        check("ovf_drained", q_out.size(), 0);

        // Backpressure with committed data, then toggled reads across wrap
        RD_READY = 1'b0;
        base = ovf_seen;
        for (int i = 0; i < 16; i++) send(32'hE0 + i, (i % 4) == 3, 0);
        check("bp_level", LEVEL, 16);
        check("bp_ready", WR_READY, 1'b0);
        check("bp_frames", FRAMES, 4);
        for (int i = 0; i < 60; i++) begin
            RD_READY = (i % 2 == 0);
            idle(1);
        end
        check("bp_no_ovf", ovf_seen - base, 0);
        check("bp_frames0", FRAMES, 0);
        check("bp_level0", LEVEL, 0);

        // Reset mid-read
        RD_READY = 1'b0;
        send(32'hF1, 0, 0);
        send(32'hF2, 1, 0);
        idle(4);
        check("pre_rst_rdv", RD_VALID, 1'b1);
        RSTN = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rdv", RD_VALID, 1'b0);
        check("mid_rst_frames", FRAMES, 0);
        check("mid_rst_level", LEVEL, 0);
        check("mid_rst_ready", WR_READY, 1'b1);
        cycle(a);
        RSTN = 1'b1;
        check("post_rst_waddr", RAM_WADDR, 0);
        check("post_rst_raddr", RAM_RADDR, 0);
        RD_READY = 1'b1;
        send(32'hD1, 0, 0);
        send(32'hD2, 1, 0);
        idle(8);
        check("post_rst_drained", q_out.size(), 0);

        // Random traffic
        rand_rd = 1;
        for (int f = 0; f < 120; f++) begin
            int len;
            bit bad;
            len = $urandom_range(1, 20);
            bad = ($urandom_range(0, 4) == 0);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send($urandom, w == len - 1, bad && (w == len - 1));
            end
        end
        rand_rd = 0;
        RD_READY = 1'b1;
        idle(100);
        check("final_drained", q_out.size(), 0);
        check("final_frames", FRAMES, 0);
        check("final_level", LEVEL, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
